// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its serializer.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;
    typedef enum logic       {ARB_IDLE, ARB_HOLD}      arb_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 bit serializer, LSB first. The tx line is registered and idles high.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      ser_ready,
    output logic                      busy,
    output logic                      tx
);
    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    ser_state_t                state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      tx_q, tx_d;
    logic                      bit_end;

    assign bit_end   = (baud_q == BAUD_LAST);
    // Accepting in the last STOP cycle lets the next start bit follow with no idle gap.
    assign ser_ready = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;

    always_comb begin
        state_d   = state_q;
        baud_d    = '0;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        if ((state_q != IDLE) && !bit_end) baud_d = baud_q + BW'(1);
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    shreg_d = data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (load) begin
                        state_d = START;
                        shreg_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART tx line among NUM_REQ byte-stream requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int MAX_BURST    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int            GW         = $clog2(NUM_REQ);
    localparam int            CW         = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    arb_state_t    arb_q, arb_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [GW-1:0] scan_id;
    logic          scan_hit;
    logic          ser_ready;
    logic          sel_valid, sel_last, xfer, release_now;
    logic [7:0]    sel_data;

    assign sel_valid   = req_valid[grant_id_q];
    assign sel_last    = req_last[grant_id_q];
    assign sel_data    = req_data[int'(grant_id_q)*8 +: 8];
    assign grant_valid = (arb_q == ARB_HOLD);
    assign grant_id    = grant_id_q;
    assign req_ready   = (grant_valid && ser_ready) ? (NUM_REQ'(1) << grant_id_q) : '0;
    assign xfer        = grant_valid && ser_ready && sel_valid;
    // Release on end of burst, on the burst cap, or when the holder has nothing to send.
    assign release_now = (xfer && (sel_last || (burst_cnt_q == BURST_LAST)))
                       || (ser_ready && !sel_valid);

    // Lowest offset from rr_ptr wins, so scan downwards and let the last hit stick.
    always_comb begin
        scan_hit = 1'b0;
        scan_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                scan_hit = 1'b1;
                scan_id  = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        arb_d       = arb_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (arb_q)
            ARB_IDLE: begin
                if (scan_hit) begin
                    arb_d       = ARB_HOLD;
                    grant_id_d  = scan_id;
                    burst_cnt_d = '0;
                end
            end
            ARB_HOLD: begin
                if (xfer) burst_cnt_d = burst_cnt_q + CW'(1);
                if (release_now) begin
                    arb_d    = ARB_IDLE;
                    rr_ptr_d = GW'((int'(grant_id_q) + 1) % NUM_REQ);
                end
            end
            default: arb_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_q       <= ARB_IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            arb_q       <= arb_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (xfer),
        .data     (sel_data),
        .ser_ready(ser_ready),
        .busy     (busy),
        .tx       (tx)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: frame shape, fairness, burst cap, back-to-back, stall release, reset.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int CPB       = 4;
    localparam int MAX_BURST = 8;
    localparam int GW        = 2;
    localparam int HIST      = 4096;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid, req_last, req_ready;
    logic [NUM_REQ*8-1:0] req_data;
    logic                 tx, busy, grant_valid;
    logic [GW-1:0]        grant_id;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CPB), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx(tx), .busy(busy), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem   [NUM_REQ][32];
    logic       mlast [NUM_REQ][32];
    int         len   [NUM_REQ];
    int         pos   [NUM_REQ];

    int            n;
    logic          tx_h  [HIST];
    logic          gv_h  [HIST];
    logic [GW-1:0] gid_h [HIST];
    int            busy_cnt, rx_cnt, onehot_bad, idle_run;
    logic          prev_gv;
    int            xf_n[$], xf_id[$], st_n[$], gr_id[$], gr_cnt[$];

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pos[i] < len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = mem[i][pos[i]];
                req_last[i]        = mlast[i][pos[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        n = 0; busy_cnt = 0; rx_cnt = 0; idle_run = 0; prev_gv = grant_valid;
        xf_n.delete(); xf_id.delete(); st_n.delete(); gr_id.delete(); gr_cnt.delete();
        for (int i = 0; i < HIST; i++) begin tx_h[i] = 1'b1; gv_h[i] = 1'b0; gid_h[i] = '0; end
    endtask

    // Sample at negedge, advance through posedge, then re-drive requesters.
    task automatic step();
        logic [NUM_REQ-1:0] hs;
        @(negedge clk);
        hs = rst ? '0 : (req_valid & req_ready);
        if ($countones(req_ready) > 1) onehot_bad++;
        if (n < HIST) begin tx_h[n] = tx; gv_h[n] = grant_valid; gid_h[n] = grant_id; end
        if (busy) busy_cnt++;
        if (!busy && !grant_valid) idle_run++; else idle_run = 0;
        if (grant_valid && !prev_gv) begin gr_id.push_back(int'(grant_id)); gr_cnt.push_back(0); end
        prev_gv = grant_valid;
        if (rx_cnt > 0) rx_cnt--;
        else if (tx == 1'b0) begin st_n.push_back(n); rx_cnt = 10*CPB - 1; end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) begin
                xf_n.push_back(n); xf_id.push_back(i);
                if (gr_cnt.size() > 0) gr_cnt[gr_cnt.size()-1]++;
                pos[i]++;
            end
        end
        n++;
        @(posedge clk); #1;
        drive();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin len[i] = 0; pos[i] = 0; end
        drive();
        step(); step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic run_until_done(input int budget, input string name);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = (idle_run >= 4);
            for (int i = 0; i < NUM_REQ; i++) if (pos[i] < len[i]) done = 0;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL %s_timeout: not idle after %0d cycles", name, budget); end
    endtask

    function automatic logic tx_at(int i);
        return (i >= 0 && i < HIST) ? tx_h[i] : 1'bx;
    endfunction

    function automatic logic [8:0] decode(int s);
        logic [7:0] b;
        logic       ok;
        ok = (tx_at(s + CPB/2) === 1'b0) && (tx_at(s + 9*CPB + CPB/2) === 1'b1);
        for (int k = 0; k < 8; k++) b[k] = tx_at(s + (k+1)*CPB + CPB/2);
        return {ok, b};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        mem[0][0] = 8'hA5; mlast[0][0] = 1'b1; len[0] = 1; pos[0] = 0;
        drive();
        step(); step();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
        checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    endtask

    task automatic test_single_byte();
        logic [9:0] exp_bits = 10'b11_0100_1010;
        int x, s;
        bit ok;
        apply_reset();
        mem[0][0] = 8'hA5; mlast[0][0] = 1'b1; len[0] = 1;
        drive();
        run_until_done(200, "single");
        x = (xf_n.size() > 0) ? xf_n[0] : -1000;
        s = (st_n.size() > 0) ? st_n[0] : -1000;
        checks++; if (gv_h[0] !== 1'b0 || gv_h[1] !== 1'b1) begin errors++; $display("FAIL single_grant_rise: gv[0]=%b gv[1]=%b want 0,1", gv_h[0], gv_h[1]); end
        checks++; if (xf_n.size() != 1 || x != 1) begin errors++; $display("FAIL single_xfer: count %0d at %0d want 1 at 1", xf_n.size(), x); end
        checks++; if (st_n.size() != 1 || s != x + 1) begin errors++; $display("FAIL single_start: count %0d at %0d want 1 at %0d", st_n.size(), s, x + 1); end
        for (int k = 0; k < 10; k++) begin
            ok = 1;
            for (int j = 0; j < CPB; j++) if (tx_at(s + k*CPB + j) !== exp_bits[k]) ok = 0;
            checks++; if (!ok) begin errors++; $display("FAIL single_bit%0d: got %b want %b", k, tx_at(s + k*CPB), exp_bits[k]); end
        end
        checks++; if (busy_cnt != 10*CPB) begin errors++; $display("FAIL single_busy: got %0d want %0d", busy_cnt, 10*CPB); end
        checks++; if (x >= 0 && gv_h[x+1] !== 1'b0) begin errors++; $display("FAIL single_release: gv=%b want 0", gv_h[x+1]); end
    endtask

    task automatic test_fairness();
        logic [7:0] e;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < 4; k++) begin mem[i][k] = 8'(16*i + k + 1); mlast[i][k] = (k % 2 == 1); end
            len[i] = 4;
        end
        drive();
        run_until_done(2000, "fair");
        checks++; if (gr_id.size() != 8) begin errors++; $display("FAIL fair_grants: got %0d want 8", gr_id.size()); end
        for (int g = 0; g < 5 && g < gr_id.size(); g++) begin
            checks++; if (gr_id[g] != g % 4) begin errors++; $display("FAIL fair_order%0d: got %0d want %0d", g, gr_id[g], g % 4); end
        end
        for (int g = 0; g < gr_cnt.size(); g++) begin
            checks++; if (gr_cnt[g] != 2) begin errors++; $display("FAIL fair_frames%0d: got %0d want 2", g, gr_cnt[g]); end
        end
        checks++; if (st_n.size() != 16) begin errors++; $display("FAIL fair_frames: got %0d want 16", st_n.size()); end
        for (int f = 0; f < st_n.size() && f < 16; f++) begin
            e = mem[(f/2) % 4][2*(f/8) + (f % 2)];
            checks++; if (decode(st_n[f]) !== {1'b1, e}) begin errors++; $display("FAIL fair_data%0d: got %h want %h", f, decode(st_n[f]), {1'b1, e}); end
        end
    endtask

    task automatic test_burst_cap();
        int exp_id[4]  = '{1, 2, 1, 1};
        int exp_cnt[4] = '{8, 1, 8, 4};
        apply_reset();
        for (int k = 0; k < 20; k++) begin mem[1][k] = 8'(8'hC0 + k); mlast[1][k] = 1'b0; end
        len[1] = 20;
        mem[2][0] = 8'h2A; mlast[2][0] = 1'b1; len[2] = 1;
        drive();
        run_until_done(3000, "cap");
        checks++; if (gr_id.size() != 4) begin errors++; $display("FAIL cap_grants: got %0d want 4", gr_id.size()); end
        for (int g = 0; g < 4 && g < gr_id.size(); g++) begin
            checks++;
            if (gr_id[g] != exp_id[g] || gr_cnt[g] != exp_cnt[g]) begin
                errors++; $display("FAIL cap_grant%0d: id %0d frames %0d want id %0d frames %0d", g, gr_id[g], gr_cnt[g], exp_id[g], exp_cnt[g]);
            end
        end
        if (st_n.size() > 8) begin
            checks++; if (decode(st_n[7]) !== 9'h1C7) begin errors++; $display("FAIL cap_data7: got %h want 1c7", decode(st_n[7])); end
            checks++; if (decode(st_n[8]) !== 9'h12A) begin errors++; $display("FAIL cap_data8: got %h want 12a", decode(st_n[8])); end
        end else begin
            checks++; errors++; $display("FAIL cap_starts: got %0d frames want 21", st_n.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h55};
        apply_reset();
        for (int k = 0; k < 3; k++) begin mem[3][k] = bytes[k]; mlast[3][k] = (k == 2); end
        len[3] = 3;
        drive();
        run_until_done(400, "b2b");
        checks++; if (xf_n.size() != 3 || gr_id.size() != 1) begin errors++; $display("FAIL b2b_xfers: got %0d xfers %0d grants want 3,1", xf_n.size(), gr_id.size()); end
        checks++; if (st_n.size() != 3) begin errors++; $display("FAIL b2b_frames: got %0d want 3", st_n.size()); end
        for (int f = 0; f < 3 && f < st_n.size(); f++) begin
            checks++; if (decode(st_n[f]) !== {1'b1, bytes[f]}) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", f, decode(st_n[f]), {1'b1, bytes[f]}); end
            if (f > 0) begin
                checks++; if (st_n[f] - st_n[f-1] != 10*CPB) begin errors++; $display("FAIL b2b_period%0d: got %0d want %0d", f, st_n[f] - st_n[f-1], 10*CPB); end
            end
        end
        checks++; if (busy_cnt != 30*CPB) begin errors++; $display("FAIL b2b_busy: got %0d want %0d", busy_cnt, 30*CPB); end
    endtask

    task automatic test_stall_release();
        int x;
        apply_reset();
        mem[0][0] = 8'h81; mlast[0][0] = 1'b0; len[0] = 1;
        mem[1][0] = 8'h7E; mlast[1][0] = 1'b1; len[1] = 1;
        drive();
        run_until_done(400, "stall");
        x = (xf_n.size() > 0) ? xf_n[0] : 0;
        checks++; if (xf_n.size() != 2 || xf_id[0] != 0) begin errors++; $display("FAIL stall_xfers: got %0d want 2 starting with req0", xf_n.size()); end
        checks++; if (gv_h[x+40] !== 1'b1 || gid_h[x+40] !== 2'd0) begin errors++; $display("FAIL stall_hold: gv=%b id=%0d want 1,0", gv_h[x+40], gid_h[x+40]); end
        checks++; if (gv_h[x+41] !== 1'b0) begin errors++; $display("FAIL stall_release: gv=%b want 0", gv_h[x+41]); end
        checks++; if (gv_h[x+42] !== 1'b1 || gid_h[x+42] !== 2'd1) begin errors++; $display("FAIL stall_regrant: gv=%b id=%0d want 1,1", gv_h[x+42], gid_h[x+42]); end
        if (xf_n.size() == 2 && st_n.size() == 2) begin
            checks++; if (xf_n[1] != x + 42 || st_n[1] != x + 43) begin errors++; $display("FAIL stall_timing: xfer %0d start %0d want %0d,%0d", xf_n[1], st_n[1], x + 42, x + 43); end
            checks++; if (decode(st_n[0]) !== 9'h181 || decode(st_n[1]) !== 9'h17E) begin errors++; $display("FAIL stall_data: got %h,%h want 181,17e", decode(st_n[0]), decode(st_n[1])); end
        end else begin
            checks++; errors++; $display("FAIL stall_frames: got %0d want 2", st_n.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int x;
        apply_reset();
        mem[0][0] = 8'hA5; mlast[0][0] = 1'b1; len[0] = 1;
        drive();
        for (int c = 0; c < 20 && xf_n.size() == 0; c++) step();
        x = (xf_n.size() > 0) ? xf_n[0] : 0;
        for (int c = 0; c < 40 && n < x + 19; c++) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        rst = 1'b1;
        step();
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || grant_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_state: tx=%b busy=%b gv=%b want 1,0,0", tx, busy, grant_valid);
        end
        rst = 1'b0;
        clear_logs();
        mem[0][0] = 8'h3C; mlast[0][0] = 1'b1; len[0] = 1; pos[0] = 0;
        drive();
        run_until_done(200, "midrst");
        checks++; if (xf_n.size() != 1 || st_n.size() != 1) begin errors++; $display("FAIL midrst_frames: xfers %0d frames %0d want 1,1", xf_n.size(), st_n.size()); end
        if (st_n.size() > 0) begin
            checks++; if (decode(st_n[0]) !== 9'h13C) begin errors++; $display("FAIL midrst_data: got %h want 13c", decode(st_n[0])); end
        end
        checks++; if (busy_cnt != 10*CPB) begin errors++; $display("FAIL midrst_busy: got %0d want %0d", busy_cnt, 10*CPB); end
    endtask

    initial begin
        onehot_bad = 0;
        for (int i = 0; i < NUM_REQ; i++) begin len[i] = 0; pos[i] = 0; end
        drive();
        clear_logs();
        test_reset();
        test_single_byte();
        test_fairness();
        test_burst_cap();
        test_back_to_back();
        test_stall_release();
        test_reset_mid_frame();
        checks++; if (onehot_bad != 0) begin errors++; $display("FAIL ready_onehot: %0d cycles with >1 ready, want 0", onehot_bad); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
